// File: rtl/booth_seq_mul.sv
// Sequential multiplier: signed radix-2 Booth or unsigned shift-add, one bit per cycle.
// Latency is size cycles from the start edge. A load seen while RUN is dropped, so there is no backpressure path.
module booth_seq_mul #(
  parameter int size = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [size-1:0]     currIn,
  input  logic                aOrb,
  input  logic                set,
  input  logic                load,
  input  logic                sgn,
  output logic                busy,
  output logic                done,
  output logic [2*size-1:0]   result
);

  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_nxt;

  logic [size-1:0] a, b;
  logic [size-1:0] mcand, mplier;
  logic [size:0]   acc;
  logic            q1;
  logic            sgn_q;
  logic [CW-1:0]   cnt;

  logic [size:0]   addend;
  logic [size:0]   sum;
  logic [size:0]   acc_nxt;
  logic [size-1:0] mplier_nxt;
  logic            do_add, do_sub;
  logic            start, last;

  // Operand registers stay writable while busy; the working copies isolate the product in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else if (!set) begin
      if (aOrb) b <= currIn;
      else      a <= currIn;
    end
  end

  always_comb begin
    addend = sgn_q ? {mcand[size-1], mcand} : {1'b0, mcand};
    do_add = sgn_q ? (~mplier[0] & q1) : mplier[0];
    do_sub = sgn_q & mplier[0] & ~q1;
    sum    = acc;
    if (do_add)      sum = acc + addend;
    else if (do_sub) sum = acc - addend;
    // In unsigned mode sum[size] is the carry, shifted into acc with a zero above it.
    acc_nxt    = {sgn_q & sum[size], sum[size:1]};
    mplier_nxt = {sum[0], mplier[size-1:1]};
  end

  assign start = load && ((state == IDLE) || (state == DONE));
  assign last  = (state == RUN) && (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = load ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      q1     <= 1'b0;
      sgn_q  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      q1     <= 1'b0;
      sgn_q  <= sgn;
      cnt    <= CW'(size);
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mplier <= mplier_nxt;
      q1     <= mplier[0];
      cnt    <= cnt - CW'(1);
      if (last) result <= {acc_nxt[size-1:0], mplier_nxt};
    end
  end

endmodule
